logs_voice_sched: RTL
=====================

Name: logs_voice_sched

Overview:
- Voice scheduler that feeds the PWM mixer's N audio input lines.
- Accepts note requests (half-period, duration) over a valid/ready handshake and assigns each to a free voice slot.
- Each active slot generates a square wave on its audio line until its duration expires; the line is then released.
- Sits between the sequencer/control logic and the mixer; audio_lines connects directly to the mixer's audio_in.

Parameters:
- N, 4, number of voice slots (= mixer input count), 1..8
- PW, 8, width of half-period field in clk cycles
- DW, 8, width of duration field in ticks
- TICK_DIV, 256, clk cycles per duration tick, >= 2

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- req_valid  input  1  note request present
- req_ready  output  1  request accepted this cycle when high with req_valid
- req_period  input  PW  square-wave half-period in clk cycles; 0 = silent note
- req_dur  input  DW  note length in ticks
- flush  input  1  synchronous kill-all pulse
- voice_active  output  N  per-slot busy flag
- audio_lines  output  N  per-slot square-wave output to mixer
- done_pulse  output  1  one-cycle pulse when any voice expires naturally

Behaviour:
- Reset (async, reset_n low): all slots idle; voice_active=0, audio_lines=0, done_pulse=0, tick prescaler=0, all counters=0. req_ready=0 while reset_n is low.
- Tick prescaler: free-running 0..TICK_DIV-1. tick=1 in the cycle the prescaler equals TICK_DIV-1. flush does not affect it.
- req_ready is combinational from registered state: (~flush) & (any slot idle).
- Accept = req_valid & req_ready at posedge.
- Allocation target: lowest-index idle slot.
- From the cycle after accept, that slot has:
  - active=1
  - line=0
  - half_cnt=req_period
  - dur_cnt=req_dur
- req_dur=0: the handshake completes, no slot is allocated, no state changes.
- Per active slot, each clk:
  - if period!=0: if half_cnt==1, toggle line and reload half_cnt=period; else decrement half_cnt. Output period = 2*period clks, first rising edge period clks after load.
  - if period==0: line held 0.
- Per active slot on tick: if dur_cnt==1, the slot goes idle next cycle (active=0, line=0) and done_pulse=1 for one cycle; otherwise dur_cnt decrements.
- A tick in the same cycle as an accept does not decrement the newly loaded slot.
- Multiple simultaneous expiries produce a single done_pulse cycle.
- A slot freed this cycle is not allocatable until the next cycle, since req_ready uses registered state.
- flush: all slots idle and all lines 0 next cycle, no done_pulse. flush has priority over accept and expiry.
- Widths: half_cnt is PW bits and dur_cnt is DW bits, with no wrap. Counters only decrement from non-zero values.

Optional Feature:
- Macro: LOGS_VOICE_STEAL_EN.
- Defined: when all slots are active and flush=0, req_ready=1.
  - Victim = slot with the smallest dur_cnt; ties go to the lowest index.
  - Victim is reloaded as on a fresh allocation (line=0, counters reloaded), with no done_pulse.
  - req_dur=0 still allocates nothing.
- Undefined: req_ready=0 when all slots are active (backpressure).

Test Plan:
1. Reset, N=4, TICK_DIV=4. Request period=3, dur=2, valid for 1 cycle -> slot0 active next cycle; audio_lines[0] rises 3 clks after load and toggles every 3 clks; slot0 idle after 2 ticks with a single done_pulse.
2. Four back-to-back requests (period 1,2,3,4; dur=5), then a fifth with valid held -> slots 0..3 filled in order; fifth waits with req_ready=0 until the first expiry, then goes to the freed lowest-index slot one cycle after expiry.
3. Request period=0, dur=3 -> voice_active[0]=1 for 3 ticks; audio_lines[0] stays 0; done_pulse fires at expiry. Request dur=0 -> handshake completes, voice_active unchanged.
4. flush asserted together with req_valid while 2 slots are active -> req_ready=0; all voice_active and audio_lines are 0 next cycle; no done_pulse.
5. reset_n driven low mid-note asynchronously (between clock edges) -> audio_lines and voice_active go to 0 immediately; after release, first request allocates slot0.
6. With LOGS_VOICE_STEAL_EN, all 4 slots active with dur_cnt 5,2,2,7 and a new request period=2, dur=9 -> req_ready=1; slot1 reloaded (dur_cnt=9, line=0); no done_pulse.

Source files
------------

// File: rtl/logs_voice_sched.sv
// Voice scheduler feeding the PWM mixer's audio inputs.
// Note requests (half-period, duration) arrive over valid/ready and are put into
// the lowest-index idle slot. Each active slot drives a square wave on its audio
// line until its duration, counted in prescaled ticks, runs out.
// Optional feature macro: LOGS_VOICE_STEAL_EN. When it is defined and every slot
// is busy, a request takes over the slot with the fewest ticks left. When it is
// undefined, a full scheduler applies backpressure.
module logs_voice_sched #(
  parameter int unsigned N        = 4,
  parameter int unsigned PW       = 8,
  parameter int unsigned DW       = 8,
  parameter int unsigned TICK_DIV = 256
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [PW-1:0] req_period,
  input  logic [DW-1:0] req_dur,
  input  logic          flush,
  output logic [N-1:0]  voice_active,
  output logic [N-1:0]  audio_lines,
  output logic          done_pulse
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0]         presc_q;
  logic                  tick;
  logic [N-1:0]          active_q, active_d;
  logic [N-1:0]          line_q, line_d;
  logic [N-1:0][PW-1:0]  period_q, period_d;
  logic [N-1:0][PW-1:0]  half_q, half_d;
  logic [N-1:0][DW-1:0]  dur_q, dur_d;
  logic                  done_q, done_d;
  logic [N-1:0]          expire;
  logic [N-1:0]          alloc_oh;
  logic [IW-1:0]         sel_idx;
  logic                  found;
  logic                  alloc;

  assign tick = (presc_q == CW'(TICK_DIV - 1));

  // Ready depends only on registered state, so a slot freed this cycle is not
  // offered until the next cycle.
`ifdef LOGS_VOICE_STEAL_EN
  assign req_ready = reset_n & ~flush;
`else
  assign req_ready = reset_n & ~flush & ~(&active_q);
`endif

  // A zero-length note completes the handshake but allocates nothing.
  assign alloc = req_valid & req_ready & (req_dur != '0);

  // Select the target slot: lowest idle index, or the steal victim when all are busy
  always_comb begin
    sel_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!active_q[i] && !found) begin
        sel_idx = IW'(i);
        found   = 1'b1;
      end
    end
`ifdef LOGS_VOICE_STEAL_EN
    if (!found) begin
      logic [DW-1:0] min_dur;
      min_dur = dur_q[0];
      sel_idx = '0;
      // Strict compare keeps ties on the lowest index.
      for (int i = 1; i < N; i++) begin
        if (dur_q[i] < min_dur) begin
          min_dur = dur_q[i];
          sel_idx = IW'(i);
        end
      end
    end
`endif
    for (int i = 0; i < N; i++) begin
      alloc_oh[i] = alloc && (sel_idx == IW'(i));
    end
  end

  // Per-slot next state: flush beats allocation, which beats wave/duration updates
  always_comb begin
    active_d = active_q;
    line_d   = line_q;
    period_d = period_q;
    half_d   = half_q;
    dur_d    = dur_q;
    expire   = '0;
    for (int i = 0; i < N; i++) begin
      if (flush) begin
        active_d[i] = 1'b0;
        line_d[i]   = 1'b0;
        period_d[i] = '0;
        half_d[i]   = '0;
        dur_d[i]    = '0;
      end else if (alloc_oh[i]) begin
        // A freshly loaded slot ignores a coincident tick.
        active_d[i] = 1'b1;
        line_d[i]   = 1'b0;
        period_d[i] = req_period;
        half_d[i]   = req_period;
        dur_d[i]    = req_dur;
      end else if (active_q[i]) begin
        if (tick && (dur_q[i] == DW'(1))) begin
          active_d[i] = 1'b0;
          line_d[i]   = 1'b0;
          expire[i]   = 1'b1;
        end else begin
          if (tick && (dur_q[i] != '0)) begin
            dur_d[i] = dur_q[i] - DW'(1);
          end
          if (period_q[i] == '0) begin
            line_d[i] = 1'b0;
          end else if (half_q[i] == PW'(1)) begin
            line_d[i] = ~line_q[i];
            half_d[i] = period_q[i];
          end else if (half_q[i] != '0) begin
            half_d[i] = half_q[i] - PW'(1);
          end
        end
      end
    end
    // Simultaneous expiries merge into one pulse; stolen slots never count.
    done_d = |expire;
  end

  // Free-running tick prescaler, untouched by flush
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + CW'(1);
    end
  end

  // Slot state and done pulse registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= '0;
      line_q   <= '0;
      period_q <= '0;
      half_q   <= '0;
      dur_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      line_q   <= line_d;
      period_q <= period_d;
      half_q   <= half_d;
      dur_q    <= dur_d;
      done_q   <= done_d;
    end
  end

  assign voice_active = active_q;
  assign audio_lines  = line_q;
  assign done_pulse   = done_q;

endmodule
